// File: rtl/display_scan_4_pkg.sv
// display_scan_4_pkg
// Shared types and constants for the four-digit seven-segment scanner.
//   seg_t        : 7-bit active-low segment pattern (bit 0 = a ... bit 6 = g)
//   SEG_BLANK    : pattern with every segment off
//   DIG_UN..MI   : digit-slot indices (units, tens, hundreds, thousands)
//   digit_set_t  : one complete display image (four patterns + blank flags)
//   anode_for()  : one-cold active-low anode vector for a digit index
package display_scan_4_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam logic [1:0] DIG_UN = 2'd0;
  localparam logic [1:0] DIG_DE = 2'd1;
  localparam logic [1:0] DIG_CE = 2'd2;
  localparam logic [1:0] DIG_MI = 2'd3;

  // Blank flag for the units digit is carried but always 0, so the
  // flags can be indexed directly by digit index like the patterns.
  typedef struct packed {
    seg_t [3:0] pat;
    logic [3:0] blank;
  } digit_set_t;

  localparam digit_set_t SET_RESET = '{pat: {4{SEG_BLANK}}, blank: 4'b0000};

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_4_scan_timer.sv
// scan_timer
// Slot counter and digit index for the display scanner.
//   clk, rst_n : clock, synchronous active-low reset
//   digit_idx  : current slot index (0..3)
//   wrap       : high on the last cycle of a slot
//   frame_end  : high on the last cycle of slot 3 (end of frame)
//   in_guard   : high during the first GUARD cycles of a slot
module scan_timer
  import display_scan_4_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] digit_idx,
  output logic       wrap,
  output logic       frame_end,
  output logic       in_guard
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);

  logic [CNT_W-1:0] slot_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= DIG_UN;
    end else if (wrap) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  assign wrap      = (slot_cnt == SLOT_LAST);
  assign frame_end = wrap && (digit_idx == DIG_MI);
  assign in_guard  = (slot_cnt < GUARD_END);

endmodule

// File: rtl/display_scan_4.sv
// display_scan_4
// Time-multiplexed scanner for a four-digit common-anode seven-segment
// display with a frame-synchronous load/ack handshake (no tearing).
//   clk, rst_n              : clock, synchronous active-low reset
//   load                    : strobe capturing patterns/digits into shadow
//   D_un, D_de, D_ce, D_mi  : active-low segment patterns, units..thousands
//   millares, centenas,
//   decenas                 : BCD digits, used only for leading-zero blanking
//   enable                  : 0 forces all anodes off
//   seg_out                 : active-low shared segment bus (registered)
//   an                      : active-low anodes, an[0] = units (registered)
//   digit_sel               : current slot index (registered)
//   ack                     : one-cycle pulse when shadow commits to active
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros of the
// thousands/hundreds/tens digits; otherwise all four digits always show.
module display_scan_4
  import display_scan_4_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] D_un,
  input  logic [6:0] D_de,
  input  logic [6:0] D_ce,
  input  logic [6:0] D_mi,
  input  logic [3:0] millares,
  input  logic [3:0] centenas,
  input  logic [3:0] decenas,
  input  logic       enable,
  output logic [6:0] seg_out,
  output logic [3:0] an,
  output logic [1:0] digit_sel,
  output logic       ack
);

  logic [1:0] digit_idx;
  logic       wrap_unused;
  logic       frame_end;
  logic       in_guard;

  scan_timer #(
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD      (GUARD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .digit_idx(digit_idx),
    .wrap     (wrap_unused),
    .frame_end(frame_end),
    .in_guard (in_guard)
  );

  logic [3:0] load_blank;

`ifdef LEADING_ZERO_BLANK_EN
  // Blanking cascades downward: a digit is blank only if it is zero and
  // every more significant digit is blank too. Units always show.
  logic blank_mi;
  logic blank_ce;
  logic blank_de;
  assign blank_mi   = (millares == 4'd0);
  assign blank_ce   = blank_mi && (centenas == 4'd0);
  assign blank_de   = blank_ce && (decenas == 4'd0);
  assign load_blank = {blank_mi, blank_ce, blank_de, 1'b0};
`else
  logic unused_digits;
  assign unused_digits = ^{millares, centenas, decenas};
  assign load_blank    = 4'b0000;
`endif

  digit_set_t load_set;
  digit_set_t shadow_set;
  digit_set_t active_set;
  logic       pending;
  logic       commit;

  assign load_set = {D_mi, D_ce, D_de, D_un, load_blank};
  assign commit   = frame_end && pending;

  // A load on the commit cycle lands in the shadow after the old shadow has
  // been transferred, so pending stays set and the new data waits one frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_set <= SET_RESET;
      active_set <= SET_RESET;
      pending    <= 1'b0;
      ack        <= 1'b0;
      seg_out    <= SEG_BLANK;
      an         <= 4'hF;
      digit_sel  <= DIG_UN;
    end else begin
      ack <= commit;
      if (commit) begin
        active_set <= shadow_set;
      end
      if (load) begin
        shadow_set <= load_set;
        pending    <= 1'b1;
      end else if (frame_end) begin
        pending    <= 1'b0;
      end
      digit_sel <= digit_idx;
      seg_out   <= active_set.blank[digit_idx] ? SEG_BLANK : active_set.pat[digit_idx];
      an        <= (!enable || in_guard) ? 4'hF : anode_for(digit_idx);
    end
  end

endmodule

// File: tb/tb_display_scan_4.sv
// tb_display_scan_4
// Self-checking bench for display_scan_4 with REFRESH_DIV = 8, GUARD = 2.
// A frame-position model (cycle index arithmetic) predicts every output on
// every cycle; directed sections pin the model with hand-computed values.
module tb_display_scan_4;

  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [6:0] D_un = 7'h7F;
  logic [6:0] D_de = 7'h7F;
  logic [6:0] D_ce = 7'h7F;
  logic [6:0] D_mi = 7'h7F;
  logic [3:0] millares = 4'd1;
  logic [3:0] centenas = 4'd1;
  logic [3:0] decenas = 4'd1;
  logic       enable = 1'b1;
  logic [6:0] seg_out;
  logic [3:0] an;
  logic [1:0] digit_sel;
  logic       ack;

  always #5 clk = ~clk;

  display_scan_4 #(
    .REFRESH_DIV(RD),
    .GUARD      (GD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .D_un     (D_un),
    .D_de     (D_de),
    .D_ce     (D_ce),
    .D_mi     (D_mi),
    .millares (millares),
    .centenas (centenas),
    .decenas  (decenas),
    .enable   (enable),
    .seg_out  (seg_out),
    .an       (an),
    .digit_sel(digit_sel),
    .ack      (ack)
  );

  int checks = 0;
  int passes = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  // Reference model: the state index m_n counts cycles since reset, so the
  // slot position, digit and frame end are plain modular arithmetic.
  logic [3:0] ONE_COLD [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int         m_n = 0;
  bit         m_valid = 1'b0;
  bit         m_pend = 1'b0;
  logic [6:0] m_sh_pat [4];
  logic [6:0] m_act_pat [4];
  logic [3:0] m_sh_blank;
  logic [3:0] m_act_blank;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic [1:0] e_sel;
  logic       e_ack;

  always @(posedge clk) begin : model
    int pos;
    int dig;
    bit fend;
    if (!rst_n) begin
      m_n = 0;
      m_pend = 1'b0;
      m_sh_blank = 4'b0;
      m_act_blank = 4'b0;
      for (int i = 0; i < 4; i++) begin
        m_sh_pat[i] = 7'h7F;
        m_act_pat[i] = 7'h7F;
      end
      e_seg = 7'h7F;
      e_an = 4'hF;
      e_sel = 2'd0;
      e_ack = 1'b0;
      m_valid = 1'b1;
    end else begin
      pos  = m_n % RD;
      dig  = (m_n / RD) % 4;
      fend = (m_n % FRAME) == FRAME - 1;
      e_sel = 2'(dig);
      e_seg = m_act_blank[dig] ? 7'h7F : m_act_pat[dig];
      e_an  = (!enable || pos < GD) ? 4'hF : ONE_COLD[dig];
      e_ack = fend && m_pend;
      if (e_ack) begin
        m_act_pat = m_sh_pat;
        m_act_blank = m_sh_blank;
      end
      if (load) begin
        m_sh_pat[0] = D_un;
        m_sh_pat[1] = D_de;
        m_sh_pat[2] = D_ce;
        m_sh_pat[3] = D_mi;
`ifdef LEADING_ZERO_BLANK_EN
        m_sh_blank[3] = (millares == 0);
        m_sh_blank[2] = m_sh_blank[3] && (centenas == 0);
        m_sh_blank[1] = m_sh_blank[2] && (decenas == 0);
`else
        m_sh_blank[3:1] = 3'b000;
`endif
        m_sh_blank[0] = 1'b0;
        m_pend = 1'b1;
      end else if (fend) begin
        m_pend = 1'b0;
      end
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_output("seg_out", 32'(seg_out), 32'(e_seg));
      check_output("an", 32'(an), 32'(e_an));
      check_output("digit_sel", 32'(digit_sel), 32'(e_sel));
      check_output("ack", 32'(ack), 32'(e_ack));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [6:0] un, input logic [6:0] de,
                                input logic [6:0] ce, input logic [6:0] mi,
                                input logic [3:0] th, input logic [3:0] hu,
                                input logic [3:0] te);
    D_un = un; D_de = de; D_ce = ce; D_mi = mi;
    millares = th; centenas = hu; decenas = te;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int guard_cnt = 0;
    while ((m_n % FRAME) != p && guard_cnt < 2 * FRAME) begin
      @(negedge clk);
      guard_cnt++;
    end
    if (guard_cnt >= 2 * FRAME) check_output("wait_pos_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_ack(input string name);
    int k = 0;
    while (ack !== 1'b1 && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check_output(name, 32'(ack), 32'd1);
  endtask

  // Watches one full frame and records, per digit, how many cycles its
  // anode was low, which anode vector and which segment pattern appeared.
  int         low_cnt [4];
  logic [3:0] an_seen [4];
  logic [6:0] seg_seen [4];
  int         on_cycles;
  int         ack_cnt;

  task automatic observe_frame();
    for (int d = 0; d < 4; d++) begin
      low_cnt[d] = 0; an_seen[d] = 4'hF; seg_seen[d] = 7'h00;
    end
    on_cycles = 0;
    ack_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ack_cnt++;
      if (an !== 4'hF) begin
        on_cycles++;
        low_cnt[digit_sel]++;
        an_seen[digit_sel] = an;
        seg_seen[digit_sel] = seg_out;
      end
    end
  endtask

  logic [6:0] pat_basic [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

  initial begin
    int k;
    logic [6:0] first_un;

    // Reset and the guard delay of the very first slot
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check_output("reset_an", 32'(an), 32'hF);
    check_output("reset_seg", 32'(seg_out), 32'h7F);
    check_output("reset_ack", 32'(ack), 32'd0);
    check_output("reset_sel", 32'(digit_sel), 32'd0);
    tick(2);
    check_output("guard_an_off", 32'(an), 32'hF);
    tick(1);
    check_output("first_anode", 32'(an), 32'b1110);

    // Basic load, committed at frame end, then one frame of display
    apply_stimulus(7'h40, 7'h79, 7'h24, 7'h30, 4'd1, 4'd2, 4'd3);
    wait_ack("basic_ack");
    observe_frame();
    for (int d = 0; d < 4; d++) begin
      check_output($sformatf("basic_low_cycles_%0d", d), 32'(low_cnt[d]), 32'd6);
      check_output($sformatf("basic_anode_%0d", d), 32'(an_seen[d]), 32'(ONE_COLD[d]));
      check_output($sformatf("basic_seg_%0d", d), 32'(seg_seen[d]), 32'(pat_basic[d]));
    end
    check_output("basic_no_extra_ack", 32'(ack_cnt), 32'd0);

    // Two loads within one frame give a single ack with the latest data
    wait_pos(2);
    apply_stimulus(7'h11, 7'h79, 7'h24, 7'h30, 4'd1, 4'd2, 4'd3);
    wait_pos(10);
    apply_stimulus(7'h12, 7'h79, 7'h24, 7'h30, 4'd1, 4'd2, 4'd3);
    ack_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ack_cnt++;
    end
    check_output("double_load_ack_count", 32'(ack_cnt), 32'd1);
    k = 0;
    while (!(digit_sel == 2'd0 && an !== 4'hF) && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check_output("double_load_units", 32'(seg_out), 32'h12);

    // Load on the frame-end cycle while pending: old shadow commits now,
    // new data commits exactly one frame later
    wait_pos(5);
    apply_stimulus(7'h01, 7'h79, 7'h24, 7'h30, 4'd1, 4'd2, 4'd3);
    wait_pos(FRAME - 1);
    apply_stimulus(7'h02, 7'h79, 7'h24, 7'h30, 4'd1, 4'd2, 4'd3);
    check_output("edge_load_first_ack", 32'(ack), 32'd1);
    k = 0;
    first_un = 7'h00;
    do begin
      @(negedge clk);
      k++;
      if (digit_sel == 2'd0 && an !== 4'hF && first_un == 7'h00) first_un = seg_out;
    end while (ack !== 1'b1 && k < 2 * FRAME);
    check_output("edge_load_ack_spacing", 32'(k), 32'd32);
    check_output("edge_load_old_units", 32'(first_un), 32'h01);

    // Leading-zero blanking: 0,0,5,x
    wait_pos(3);
    apply_stimulus(7'h40, 7'h12, 7'h24, 7'h30, 4'd0, 4'd0, 4'd5);
    wait_ack("blank_ack");
    observe_frame();
    check_output("blank_seg_0", 32'(seg_seen[0]), 32'h40);
    check_output("blank_seg_1", 32'(seg_seen[1]), 32'h12);
`ifdef LEADING_ZERO_BLANK_EN
    check_output("blank_seg_2", 32'(seg_seen[2]), 32'h7F);
    check_output("blank_seg_3", 32'(seg_seen[3]), 32'h7F);
`else
    check_output("blank_seg_2", 32'(seg_seen[2]), 32'h24);
    check_output("blank_seg_3", 32'(seg_seen[3]), 32'h30);
`endif

    // Disabled for a whole frame: anodes stay off, commit still happens
    wait_pos(3);
    apply_stimulus(7'h79, 7'h79, 7'h79, 7'h79, 4'd1, 4'd1, 4'd1);
    enable = 1'b0;
    observe_frame();
    enable = 1'b1;
    check_output("disabled_anode_cycles", 32'(on_cycles), 32'd0);
    check_output("disabled_ack_count", 32'(ack_cnt), 32'd1);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 800; i++) begin
      D_un = 7'($urandom); D_de = 7'($urandom);
      D_ce = 7'($urandom); D_mi = 7'($urandom);
      millares = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
      centenas = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
      decenas  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
      load   = ($urandom_range(0, 9) == 0);
      enable = ($urandom_range(0, 7) != 0);
      @(negedge clk);
    end
    load = 1'b0;
    enable = 1'b1;

    // Reset mid-frame drops pending data without an ack
    wait_pos(4);
    apply_stimulus(7'h08, 7'h08, 7'h08, 7'h08, 4'd1, 4'd1, 4'd1);
    wait_pos(12);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ack_cnt++;
    end
    check_output("reset_drops_pending", 32'(ack_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
